glb_cfg_req_ctrl: RTL and testbench



---
 rtl/glb_cfg_req_ctrl_if.sv | 44 ++++
 rtl/glb_cfg_req_ctrl.sv | 144 ++++++++++++++
 tb/tb_glb_cfg_req_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/glb_cfg_req_ctrl_if.sv
// Bundle of the request/response stream and the if_cfg tile-chain port
// used by glb_cfg_req_ctrl. The "slave" modport is the sequencer side.
interface glb_cfg_req_ctrl_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 12,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    // request stream
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic [AXI_DATA_WIDTH-1:0] req_data;
    // response stream
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [AXI_DATA_WIDTH-1:0] rsp_data;
    logic                      rsp_err;
    // tile-chain config port
    logic                      if_cfg_wr_en;
    logic                      if_cfg_wr_clk_en;
    logic [AXI_ADDR_WIDTH-1:0] if_cfg_wr_addr;
    logic [AXI_DATA_WIDTH-1:0] if_cfg_wr_data;
    logic                      if_cfg_rd_en;
    logic                      if_cfg_rd_clk_en;
    logic [AXI_ADDR_WIDTH-1:0] if_cfg_rd_addr;
    logic [AXI_DATA_WIDTH-1:0] if_cfg_rd_data;
    logic                      if_cfg_rd_data_valid;

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready,
               if_cfg_rd_data, if_cfg_rd_data_valid,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               if_cfg_wr_en, if_cfg_wr_clk_en, if_cfg_wr_addr, if_cfg_wr_data,
               if_cfg_rd_en, if_cfg_rd_clk_en, if_cfg_rd_addr
    );

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready,
               if_cfg_rd_data, if_cfg_rd_data_valid,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               if_cfg_wr_en, if_cfg_wr_clk_en, if_cfg_wr_addr, if_cfg_wr_data,
               if_cfg_rd_en, if_cfg_rd_clk_en, if_cfg_rd_addr
    );
endinterface

// File: rtl/glb_cfg_req_ctrl.sv
// Upstream config-request sequencer for the GLB tile chain. Turns one
// valid/ready request at a time into a single-cycle if_cfg write or read
// strobe, waits (bounded) for the read return and emits one response.
module glb_cfg_req_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 12,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned RD_TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               reset,
    glb_cfg_req_ctrl_if.slave  bus
);
    localparam int unsigned       CNT_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      wr_en_q, wr_en_d;
    logic                      wr_clk_en_q, wr_clk_en_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      rd_en_q, rd_en_d;
    logic                      rd_clk_en_q, rd_clk_en_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;

    // Next-state and next-output logic; strobes are computed one state ahead
    // so they are registered and land exactly in the WR / RD_ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_clk_en_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_clk_en_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_write) begin
                        state_d     = WR;
                        wr_en_d     = 1'b1;
                        wr_clk_en_d = 1'b1;
                        wr_addr_d   = bus.req_addr;
                        wr_data_d   = bus.req_data;
                    end else begin
                        state_d     = RD_ISSUE;
                        rd_en_d     = 1'b1;
                        rd_clk_en_d = 1'b1;
                        rd_addr_d   = bus.req_addr;
                    end
                end
            end
            WR: begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RD_ISSUE: begin
                cnt_d       = '0;
                rd_clk_en_d = 1'b1;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                // a return on the last allowed cycle beats the timeout
                if (bus.if_cfg_rd_data_valid) begin
                    rsp_data_d = bus.if_cfg_rd_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    rd_clk_en_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async active-low reset drops any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_clk_en_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_clk_en_q <= 1'b0;
            rd_addr_q   <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_clk_en_q <= wr_clk_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_clk_en_q <= rd_clk_en_d;
            rd_addr_q   <= rd_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready        = (state_q == IDLE);
    assign bus.rsp_valid        = (state_q == RESP);
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.if_cfg_wr_en     = wr_en_q;
    assign bus.if_cfg_wr_clk_en = wr_clk_en_q;
    assign bus.if_cfg_wr_addr   = wr_addr_q;
    assign bus.if_cfg_wr_data   = wr_data_q;
    assign bus.if_cfg_rd_en     = rd_en_q;
    assign bus.if_cfg_rd_clk_en = rd_clk_en_q;
    assign bus.if_cfg_rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_glb_cfg_req_ctrl.sv
// Directed bench for glb_cfg_req_ctrl: a vector table of single requests
// with hand-computed latency/response, plus hand sequences for stray
// read returns and reset during a read wait.
module tb_glb_cfg_req_ctrl;
    logic clk;
    logic reset;

    int n_chk;
    int n_pass;

    glb_cfg_req_ctrl_if #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) bus_if ();

    glb_cfg_req_ctrl #(
        .AXI_ADDR_WIDTH(12),
        .AXI_DATA_WIDTH(32),
        .RD_TIMEOUT    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;      // write data, or read-return data
        int          vwait;     // wait-cycle index of read return, -1 = never
        int          hold;      // cycles rsp_ready stays low in RESP
        int          exp_lat;   // cycles from accept edge to rsp_valid
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          cyc;
        int          wr_cnt;
        int          rd_cnt;
        int          wr_at;
        int          rd_at;
        int          both;
        int          gap;
        logic [11:0] s_addr;
        logic [31:0] s_data;
        logic [31:0] held;
        wr_cnt = 0; rd_cnt = 0; wr_at = 0; rd_at = 0; both = 0; gap = 0;
        s_addr = '0; s_data = '0;

        chk({tag, "_req_ready_idle"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = v.wr;
        bus_if.req_addr  = v.addr;
        bus_if.req_data  = v.data;
        bus_if.rsp_ready = (v.hold == 0);
        step();
        bus_if.req_valid = 1'b0;
        bus_if.req_data  = 32'h0;
        chk({tag, "_req_ready_busy"}, 32'(bus_if.req_ready), 32'd0);

        cyc = 1;
        while (!bus_if.rsp_valid && cyc < 40) begin
            if (bus_if.if_cfg_wr_en) begin
                wr_cnt++; wr_at = cyc;
                s_addr = bus_if.if_cfg_wr_addr; s_data = bus_if.if_cfg_wr_data;
            end
            if (bus_if.if_cfg_rd_en) begin
                rd_cnt++; rd_at = cyc; s_addr = bus_if.if_cfg_rd_addr;
            end
            if (bus_if.if_cfg_wr_en && bus_if.if_cfg_rd_en) both++;
            if (!v.wr && !bus_if.if_cfg_rd_clk_en) gap++;
            if (v.vwait >= 0 && cyc == v.vwait + 2) begin
                bus_if.if_cfg_rd_data_valid = 1'b1;
                bus_if.if_cfg_rd_data       = v.data;
            end else begin
                bus_if.if_cfg_rd_data_valid = 1'b0;
                bus_if.if_cfg_rd_data       = 32'hBAD0_0BAD;
            end
            step();
            cyc++;
        end
        bus_if.if_cfg_rd_data_valid = 1'b0;

        chk({tag, "_rsp_latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({tag, "_both_strobes"}, 32'(both), 32'd0);
        if (v.wr) begin
            chk({tag, "_wr_strobes"}, 32'(wr_cnt), 32'd1);
            chk({tag, "_rd_strobes"}, 32'(rd_cnt), 32'd0);
            chk({tag, "_wr_cycle"}, 32'(wr_at), 32'd1);
            chk({tag, "_wr_addr"}, 32'(s_addr), 32'(v.addr));
            chk({tag, "_wr_data"}, s_data, v.data);
        end else begin
            chk({tag, "_rd_strobes"}, 32'(rd_cnt), 32'd1);
            chk({tag, "_wr_strobes"}, 32'(wr_cnt), 32'd0);
            chk({tag, "_rd_cycle"}, 32'(rd_at), 32'd1);
            chk({tag, "_rd_addr"}, 32'(s_addr), 32'(v.addr));
            chk({tag, "_rd_clk_en_gaps"}, 32'(gap), 32'd0);
            chk({tag, "_rd_addr_held"}, 32'(bus_if.if_cfg_rd_addr), 32'(v.addr));
        end
        chk({tag, "_rsp_data"}, bus_if.rsp_data, v.exp_data);
        chk({tag, "_rsp_err"}, 32'(bus_if.rsp_err), 32'(v.exp_err));
        chk({tag, "_resp_clk_ens"}, 32'({bus_if.if_cfg_wr_clk_en, bus_if.if_cfg_rd_clk_en}), 32'd0);

        // back-pressure: a second request is offered but must not be taken
        held = bus_if.rsp_data;
        for (int h = 0; h < v.hold; h++) begin
            bus_if.rsp_ready = 1'b0;
            bus_if.req_valid = 1'b1;
            bus_if.req_write = 1'b1;
            bus_if.req_addr  = 12'h3FC;
            bus_if.req_data  = 32'h5555_5555;
            step();
            chk($sformatf("%s_hold%0d_state", tag, h),
                32'({bus_if.rsp_valid, bus_if.req_ready, bus_if.if_cfg_wr_en}), 32'b100);
            chk($sformatf("%s_hold%0d_data", tag, h), bus_if.rsp_data, held);
        end

        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        step();
        chk({tag, "_after_handshake"},
            32'({bus_if.rsp_valid, bus_if.if_cfg_wr_en, bus_if.req_ready}), 32'b001);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, 32'({bus_if.if_cfg_wr_en, bus_if.if_cfg_wr_clk_en,
            bus_if.if_cfg_rd_en, bus_if.if_cfg_rd_clk_en, bus_if.rsp_valid,
            bus_if.rsp_err, bus_if.req_ready}), 32'b0000001);
        chk({tag, "_addrs"}, 32'({bus_if.if_cfg_wr_addr, bus_if.if_cfg_rd_addr}), 32'd0);
        chk({tag, "_wr_data"}, bus_if.if_cfg_wr_data, 32'd0);
        chk({tag, "_rsp_data"}, bus_if.rsp_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   stray;
        vec_t v;
        n_chk  = 0;
        n_pass = 0;

        //            wr    addr     data          vw  hold lat  exp_data      err
        vecs[0] = '{1'b1, 12'h014, 32'hDEADBEEF, -1, 0,   2, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 12'h020, 32'h12345678,  2, 0,   5, 32'h12345678, 1'b0};
        vecs[2] = '{1'b0, 12'h7FC, 32'h0BADF00D, 15, 0,  18, 32'h0BADF00D, 1'b0};
        vecs[3] = '{1'b1, 12'hFFF, 32'hFFFFFFFF, -1, 0,   2, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 12'h040, 32'hA5A5A5A5,  0, 0,   3, 32'hA5A5A5A5, 1'b0};
        vecs[5] = '{1'b0, 12'h044, 32'hCAFEF00D,  5, 5,   8, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b0, 12'h030, 32'h0,        -1, 0,  18, 32'h0,        1'b1};

        reset = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_data  = '0;
        bus_if.rsp_ready = 1'b1;
        bus_if.if_cfg_rd_data       = '0;
        bus_if.if_cfg_rd_data_valid = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // late return two cycles after the timeout response: must be ignored
        step();
        bus_if.if_cfg_rd_data_valid = 1'b1;
        bus_if.if_cfg_rd_data       = 32'hBAD0BAD0;
        step();
        bus_if.if_cfg_rd_data_valid = 1'b0;
        chk("stray_rsp_valid", 32'({bus_if.rsp_valid, bus_if.req_ready}), 32'b01);
        chk("stray_rsp_data", bus_if.rsp_data, 32'h0);
        chk("stray_rsp_err", 32'(bus_if.rsp_err), 32'd1);
        v = '{1'b0, 12'h050, 32'h600DD00D, 1, 0, 4, 32'h600DD00D, 1'b0};
        run_vec("after_stray", v);

        // reset while waiting for a read return
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 12'h060;
        step();
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_rd_clk_en", 32'(bus_if.if_cfg_rd_clk_en), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.rsp_valid || !bus_if.req_ready) stray++;
            step();
        end
        chk("post_reset_no_rsp", 32'(stray), 32'd0);
        v = '{1'b1, 12'h0A8, 32'h01234567, -1, 0, 2, 32'h0, 1'b0};
        run_vec("post_reset_wr", v);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
